// File: rtl/alu_nibble_serial_ctrl_if.sv
// alu_nibble_serial_ctrl_if: command handshake plus 4-bit ALU slice bus for the nibble-serial controller
interface alu_nibble_serial_ctrl_if #(parameter int W = 16);
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   op_s;
  logic         op_cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [1:0]   alu_s;
  logic         alu_cin;
  logic [3:0]   alu_f;
  logic         alu_cout;
  modport master (
    input  start, op_a, op_b, op_s, op_cin, alu_f, alu_cout,
    output busy, done, result, cout, alu_a, alu_b, alu_s, alu_cin
  );
  modport slave (
    output start, op_a, op_b, op_s, op_cin, alu_f, alu_cout,
    input  busy, done, result, cout, alu_a, alu_b, alu_s, alu_cin
  );
endinterface

// File: rtl/alu_nibble_serial_ctrl.sv
// alu_nibble_serial_ctrl: drives a shared 4-bit ALU slice one nibble per clock, low nibble first
module alu_nibble_serial_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst_n,
  alu_nibble_serial_ctrl_if.master bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]     s_q, s_d;
  logic           cin_q, cin_d, carry_q, carry_d, cout_q, cout_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           run, last;
  assign run  = state_q == RUN;
  assign last = idx_q == IW'(NIBBLES - 1);
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    idx_d    = idx_q;
    result_d = result_q;
    if (!run && bus.start) begin
      state_d = RUN;
      a_d     = bus.op_a;
      b_d     = bus.op_b;
      s_d     = bus.op_s;
      cin_d   = bus.op_cin;
      carry_d = bus.op_cin;
      idx_d   = '0;
    end else if (run) begin
      result_d[idx_q*4 +: 4] = bus.alu_f;
      a_d     = a_q >> 4;
      b_d     = b_q >> 4;
      idx_d   = last ? '0 : idx_q + 1'b1;
      // carry only chains for ADD; other functions see the original carry-in on every nibble
      carry_d = (s_q == 2'b11) ? bus.alu_cout : cin_q;
      cout_d  = last ? bus.alu_cout : cout_q;
      state_d = last ? DONE : RUN;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end
  assign bus.busy    = run;
  assign bus.done    = state_q == DONE;
  assign bus.result  = result_q;
  assign bus.cout    = cout_q;
  assign bus.alu_a   = run ? a_q[3:0] : 4'h0;
  assign bus.alu_b   = run ? b_q[3:0] : 4'h0;
  assign bus.alu_s   = run ? s_q : 2'b00;
  assign bus.alu_cin = run ? carry_q : 1'b0;
endmodule

// File: tb/tb_alu_nibble_serial_ctrl.sv
// tb_alu_nibble_serial_ctrl: directed scoreboard bench with a behavioural 4-bit slice on the ALU side
module tb_alu_nibble_serial_ctrl;
  localparam int N = 4;
  localparam int W = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_nibble_serial_ctrl_if #(.W(W)) bus ();
  alu_nibble_serial_ctrl #(.NIBBLES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // slice stand-in: 0=AND 1=OR 2=XOR 3=ADD
  logic [4:0] slice_sum;
  assign slice_sum    = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_cin};
  assign bus.alu_f    = bus.alu_s == 2'b11 ? slice_sum[3:0] :
                        bus.alu_s == 2'b00 ? bus.alu_a & bus.alu_b :
                        bus.alu_s == 2'b01 ? bus.alu_a | bus.alu_b : bus.alu_a ^ bus.alu_b;
  assign bus.alu_cout = bus.alu_s == 2'b11 && slice_sum[4];
  int checks = 0;
  int errors = 0;
  logic [16:0] exp_q[$];
  function automatic logic [16:0] ref_op(logic [15:0] a, logic [15:0] b, logic [1:0] s, logic cin);
    case (s)
      2'b11:   return {1'b0, a} + {1'b0, b} + {16'b0, cin};
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic issue(logic [15:0] a, logic [15:0] b, logic [1:0] s, logic cin, bit push);
    bus.start  = 1'b1;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.op_s   = s;
    bus.op_cin = cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) exp_q.push_back(ref_op(a, b, s, cin));
  endtask
  task automatic wait_done(string tag, output int busy_n, output logic [3:0] cins);
    bit got;
    logic [16:0] e;
    got = 0;
    busy_n = 0;
    cins = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (bus.done) got = 1;
      else begin
        if (bus.busy && busy_n < 4) cins[busy_n] = bus.alu_cin;
        if (bus.busy) busy_n++;
        @(posedge clk);
        #1;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 1);
    if (got) begin
      chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({tag, "_result"}, 32'(bus.result), 32'(e[15:0]));
        chk({tag, "_cout"}, 32'(bus.cout), 32'(e[16]));
      end
    end
  endtask
  task automatic chk_idle_outputs(string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_result"}, 32'(bus.result), 0);
    chk({tag, "_cout"}, 32'(bus.cout), 0);
    chk({tag, "_alu_bus"}, {21'b0, bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_cin}, 0);
  endtask
  initial begin
    int n;
    int dones;
    logic [3:0] cins;
    bus.start  = 1'b0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.op_s   = 2'b11;
    bus.op_cin = 1'b0;
    #12;
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(16'h0001, 16'h0003, 2'b11, 1'b0, 1);
    wait_done("t1", n, cins);
    chk("t1_busy_cycles", 32'(n), 4);
    @(posedge clk);
    #1;
    chk("t1_done_one_cycle", 32'(bus.done), 0);
    chk("t1_result_held", 32'(bus.result), 32'h0004);
    issue(16'hFFFF, 16'h0001, 2'b11, 1'b0, 1);
    wait_done("t2", n, cins);
    chk("t2_carry_chain", 32'(cins), 32'b1110);
    @(posedge clk);
    #1;
    issue(16'hFFFF, 16'hFFFF, 2'b11, 1'b1, 1);
    wait_done("t3", n, cins);
    issue(16'h8000, 16'h7FFF, 2'b11, 1'b0, 1);
    chk("t3b_busy_after_b2b", 32'(bus.busy), 1);
    wait_done("t3b", n, cins);
    chk("t3b_busy_cycles", 32'(n), 4);
    @(posedge clk);
    #1;
    issue(16'h1234, 16'h1111, 2'b11, 1'b0, 1);
    bus.start = 1'b1;
    bus.op_a  = 16'h0F0F;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("t4", n, cins);
    chk("t4_busy_left", 32'(n), 3);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    chk("t4_single_done", 32'(dones), 0);
    issue(16'hF0F0, 16'h3C3C, 2'b00, 1'b1, 1);
    wait_done("t5", n, cins);
    chk("t5_no_chain", 32'(cins), 32'b1111);
    @(posedge clk);
    #1;
    issue(16'h5A5A, 16'hA5A5, 2'b11, 1'b0, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("t6_abort");
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    chk("t6_no_done", 32'(dones), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_idle_after_release", 32'(bus.busy | bus.done), 0);
    issue(16'h0101, 16'h1010, 2'b11, 1'b0, 1);
    wait_done("t6", n, cins);
    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_nibble_serial_ctrl.md
Name: alu_nibble_serial_ctrl

Overview:
Sequential initiator that performs a wide ALU operation by driving the team's combinational 4-bit ALU slice (alu_4bit_struct) one nibble per clock, low nibble first. It chains carry between nibbles for ADD (S=2'b11). It assembles the wide result and flags completion with a start/busy/done handshake. It sits between a command source (CPU datapath or bench) and a single shared 4-bit ALU instance.

Parameters:
NIBBLES, 4, number of 4-bit slices processed; operand/result width W = 4*NIBBLES (minimum 2).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  command strobe; sampled on rising clk.
op_a  input  W  operand A.
op_b  input  W  operand B.
op_s  input  2  ALU function select, passed unchanged to the slice.
op_cin  input  1  carry-in for nibble 0.
busy  output  1  high while a command is in progress.
done  output  1  one-cycle pulse; result/cout valid.
result  output  W  assembled result, held until the next accepted command.
cout  output  1  final carry-out (alu_cout of the top nibble), held with result.
alu_a  output  4  A nibble to the slice.
alu_b  output  4  B nibble to the slice.
alu_s  output  2  select to the slice.
alu_cin  output  1  carry-in to the slice.
alu_f  input  4  slice result (combinational from alu_a/alu_b/alu_s/alu_cin).
alu_cout  input  1  slice carry-out.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, cout=0, alu_a=0, alu_b=0, alu_s=0, alu_cin=0, nibble index=0. Reset mid-operation aborts the command; no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE + start=1: latch op_a, op_b, op_s and op_cin into internal shift registers. Set index=0, carry register=op_cin. Go to RUN with busy=1.
- IDLE + start=0: stay in IDLE. DONE + start=0: go to IDLE.
- A start in DONE is accepted, giving back-to-back commands. A start while in RUN is ignored, and operands are not re-latched.
- RUN, each cycle:
  - alu_a and alu_b = current low nibble of the A/B shift registers; alu_s = latched S; alu_cin = carry register.
  - On the clock edge, alu_f is written into result nibble [index]. Both shift registers shift right 4 bits and index increments.
  - Carry register <= alu_cout when latched S=2'b11. Otherwise it is reloaded with latched op_cin (no chaining for non-ADD functions).
- Last nibble (index=NIBBLES-1): on that edge, capture alu_f into the top nibble and cout <= alu_cout. Go to DONE with busy=0, done=1.
- DONE lasts exactly one cycle.
- Latency: start sampled at edge E0. The slice is driven for NIBBLES cycles. done is high in the cycle after edge E0+NIBBLES (4-nibble default: done after the 4th RUN edge). Throughput is one command per NIBBLES+1 cycles.
- result is updated nibble-by-nibble during RUN and is only guaranteed valid when done=1. It is held thereafter until the next accepted start.
- In IDLE and DONE, alu_a/alu_b/alu_cin/alu_s are driven 0.
- ADD arithmetic is full W-bit unsigned: {cout,result} = op_a + op_b + op_cin.

Test Plan:
- Bench: controller connected to an alu_4bit_struct instance, NIBBLES=4, S=2'b11.
- A=16'h0001, B=16'h0003, Cin=0, start pulse -> done on 5th cycle after start edge; result=16'h0004, cout=0; busy high exactly 4 cycles.
- A=16'hFFFF, B=16'h0001, Cin=0 -> result=16'h0000, cout=1; alu_cin=1 observed on nibbles 1-3.
- A=16'hFFFF, B=16'hFFFF, Cin=1 -> result=16'hFFFF, cout=1. Then A=16'h8000, B=16'h7FFF, Cin=0 with start held in the DONE cycle (back-to-back) -> result=16'hFFFF, cout=0.
- Start with A=16'h1234, B=16'h1111, then re-pulse start with A=16'h0F0F during RUN -> re-pulse ignored; result=16'h2345, single done pulse.
- Start A=16'h5A5A, B=16'hA5A5, then assert rst_n=0 after the 2nd RUN cycle -> all outputs 0 immediately, no done. After release, a new command A=16'h0101, B=16'h1010 -> result=16'h1111, cout=0.
